// File: rtl/walk_light_controller.sv
// Pedestrian/side-road traffic sequencer: consumes latched walk requests, runs the
// phase timer, drives registered lamp outputs and pulses the request-register clear.
module walk_light_controller #(
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_WALK   = 6,
  parameter int TW       = 8
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       walk_req_1,
  input  logic       walk_req_2,
  input  logic       side_sensor,
  output logic       wr_clear,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk_lamp_1,
  output logic       walk_lamp_2
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_SIDE_GREEN  = 3'd2,
    S_SIDE_YELLOW = 3'd3,
    S_WALK        = 3'd4
  } state_t;

  localparam logic [TW-1:0] LD_GREEN  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] LD_YELLOW = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] LD_WALK   = TW'(T_WALK - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          w_expired;
  logic          w_any_walk;
  logic          w_enter_walk;
  logic [2:0]    w_main_nxt;
  logic [2:0]    w_side_nxt;
  logic          w_walk1_nxt;
  logic          w_walk2_nxt;

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      r_state     <= S_MAIN_GREEN;
      r_timer     <= LD_GREEN;
      main_lamp   <= LAMP_GREEN;
      side_lamp   <= LAMP_RED;
      walk_lamp_1 <= 1'b0;
      walk_lamp_2 <= 1'b0;
      wr_clear    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      main_lamp   <= w_main_nxt;
      side_lamp   <= w_side_nxt;
      walk_lamp_1 <= w_walk1_nxt;
      walk_lamp_2 <= w_walk2_nxt;
      wr_clear    <= w_enter_walk;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_main_nxt  = LAMP_GREEN;
    w_side_nxt  = LAMP_RED;
    w_walk1_nxt = 1'b0;
    w_walk2_nxt = 1'b0;
    w_expired   = (r_timer == TW'(0));
    w_any_walk  = walk_req_1 | walk_req_2;

    case (r_state)
      S_MAIN_GREEN: begin
        if (w_expired && (w_any_walk || side_sensor)) w_state_nxt = S_MAIN_YELLOW;
        else                                         w_state_nxt = S_MAIN_GREEN;
      end
      // Walk wins over the side road; a withdrawn request falls back to main green.
      S_MAIN_YELLOW: begin
        if (!w_expired)       w_state_nxt = S_MAIN_YELLOW;
        else if (w_any_walk)  w_state_nxt = S_WALK;
        else if (side_sensor) w_state_nxt = S_SIDE_GREEN;
        else                  w_state_nxt = S_MAIN_GREEN;
      end
      S_SIDE_GREEN: begin
        if (w_expired) w_state_nxt = S_SIDE_YELLOW;
        else           w_state_nxt = S_SIDE_GREEN;
      end
      S_SIDE_YELLOW: begin
        if (w_expired) w_state_nxt = S_MAIN_GREEN;
        else           w_state_nxt = S_SIDE_YELLOW;
      end
      S_WALK: begin
        if (w_expired) w_state_nxt = S_MAIN_GREEN;
        else           w_state_nxt = S_WALK;
      end
      default: w_state_nxt = S_MAIN_GREEN;
    endcase

    w_enter_walk = (w_state_nxt == S_WALK) && (r_state != S_WALK);

    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_MAIN_GREEN:  w_timer_nxt = LD_GREEN;
        S_SIDE_GREEN:  w_timer_nxt = LD_GREEN;
        S_MAIN_YELLOW: w_timer_nxt = LD_YELLOW;
        S_SIDE_YELLOW: w_timer_nxt = LD_YELLOW;
        S_WALK:        w_timer_nxt = LD_WALK;
        default:       w_timer_nxt = LD_GREEN;
      endcase
    end else if (!w_expired) begin
      w_timer_nxt = r_timer - TW'(1);
    end else begin
      w_timer_nxt = r_timer;
    end

    case (w_state_nxt)
      S_MAIN_GREEN:  begin w_main_nxt = LAMP_GREEN;  w_side_nxt = LAMP_RED;    end
      S_MAIN_YELLOW: begin w_main_nxt = LAMP_YELLOW; w_side_nxt = LAMP_RED;    end
      S_SIDE_GREEN:  begin w_main_nxt = LAMP_RED;    w_side_nxt = LAMP_GREEN;  end
      S_SIDE_YELLOW: begin w_main_nxt = LAMP_RED;    w_side_nxt = LAMP_YELLOW; end
      S_WALK:        begin w_main_nxt = LAMP_RED;    w_side_nxt = LAMP_RED;    end
      default:       begin w_main_nxt = LAMP_GREEN;  w_side_nxt = LAMP_RED;    end
    endcase

    // Crossings are captured once on WALK entry; later requests wait for the next cycle.
    if (w_enter_walk) begin
      w_walk1_nxt = walk_req_1;
      w_walk2_nxt = walk_req_2;
    end else if (w_state_nxt == S_WALK) begin
      w_walk1_nxt = walk_lamp_1;
      w_walk2_nxt = walk_lamp_2;
    end else begin
      w_walk1_nxt = 1'b0;
      w_walk2_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_walk_light_controller.sv
// Table-driven bench for walk_light_controller (T_GREEN=4, T_YELLOW=2, T_WALK=3),
// with a behavioural walk-request latch that honours wr_clear.
module tb_walk_light_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    logic       s1;
    logic       s2;
    logic       sen;
    logic [2:0] m;
    logic [2:0] s;
    logic       w1;
    logic       w2;
    logic       clr;
  } vec_t;

  logic       clk = 1'b0;
  logic       g_reset = 1'b1;
  logic       set1 = 1'b0;
  logic       set2 = 1'b0;
  logic       side_sensor = 1'b0;
  logic       lat1;
  logic       lat2;
  logic       walk_req_1;
  logic       walk_req_2;
  logic       wr_clear;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk_lamp_1;
  logic       walk_lamp_2;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t q[$];

  walk_light_controller #(.T_GREEN(4), .T_YELLOW(2), .T_WALK(3), .TW(8)) dut (
    .clk(clk), .g_reset(g_reset), .walk_req_1(walk_req_1), .walk_req_2(walk_req_2),
    .side_sensor(side_sensor), .wr_clear(wr_clear), .main_lamp(main_lamp),
    .side_lamp(side_lamp), .walk_lamp_1(walk_lamp_1), .walk_lamp_2(walk_lamp_2)
  );

  always #5 clk = ~clk;

  // Walk-request register: a set is visible immediately, clear wins at the edge.
  assign walk_req_1 = lat1 | set1;
  assign walk_req_2 = lat2 | set2;
  always @(posedge clk or posedge g_reset) begin
    if (g_reset)       begin lat1 <= 1'b0;       lat2 <= 1'b0;       end
    else if (wr_clear) begin lat1 <= 1'b0;       lat2 <= 1'b0;       end
    else               begin lat1 <= walk_req_1; lat2 <= walk_req_2; end
  end

  task automatic add(input int n, input logic s1, input logic s2, input logic sen,
                     input logic [2:0] m, input logic [2:0] s,
                     input logic w1, input logic w2, input logic clr);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.sen = sen; v.m = m; v.s = s; v.w1 = w1; v.w2 = w2; v.clr = clr;
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] em, input logic [2:0] es,
                       input logic ew1, input logic ew2, input logic eclr);
    n_tests++;
    if ({main_lamp, side_lamp, walk_lamp_1, walk_lamp_2, wr_clear} !==
        {em, es, ew1, ew2, eclr}) begin
      n_fail++;
      $display("FAIL %s: got main=%b side=%b w1=%b w2=%b clr=%b, want main=%b side=%b w1=%b w2=%b clr=%b",
               name, main_lamp, side_lamp, walk_lamp_1, walk_lamp_2, wr_clear,
               em, es, ew1, ew2, eclr);
    end
  endtask

  task automatic do_reset();
    set1 = 1'b0; set2 = 1'b0; side_sensor = 1'b0;
    g_reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    g_reset = 1'b0;
  endtask

  // Each vector: compare outputs of the current cycle, then drive that cycle's inputs.
  task automatic run_seq(input string name, input bit rst_first);
    if (rst_first) do_reset();
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s[c%0d]", name, i), q[i].m, q[i].s, q[i].w1, q[i].w2, q[i].clr);
      set1 = q[i].s1; set2 = q[i].s2; side_sensor = q[i].sen;
      @(posedge clk);
      @(negedge clk);
    end
    set1 = 1'b0; set2 = 1'b0; side_sensor = 1'b0;
    q.delete();
  endtask

  initial begin
    // Idle: main green indefinitely.
    add(20, 0, 0, 0, G, R, 0, 0, 0);
    run_seq("idle", 1'b1);

    // Walk request on crossing 1.
    add(1, 1, 0, 0, G, R, 0, 0, 0);
    add(3, 0, 0, 0, G, R, 0, 0, 0);
    add(2, 0, 0, 0, Y, R, 0, 0, 0);
    add(1, 0, 0, 0, R, R, 1, 0, 1);
    add(2, 0, 0, 0, R, R, 1, 0, 0);
    add(4, 0, 0, 0, G, R, 0, 0, 0);
    run_seq("walk1", 1'b1);

    // Side road only.
    add(4, 0, 0, 1, G, R, 0, 0, 0);
    add(2, 0, 0, 1, Y, R, 0, 0, 0);
    add(4, 0, 0, 1, R, G, 0, 0, 0);
    add(2, 0, 0, 1, R, Y, 0, 0, 0);
    add(5, 0, 0, 0, G, R, 0, 0, 0);
    run_seq("side", 1'b1);

    // Walk 2 and side together: walk first, side on the next pass.
    add(1, 0, 1, 1, G, R, 0, 0, 0);
    add(3, 0, 0, 1, G, R, 0, 0, 0);
    add(2, 0, 0, 1, Y, R, 0, 0, 0);
    add(1, 0, 0, 1, R, R, 0, 1, 1);
    add(2, 0, 0, 1, R, R, 0, 1, 0);
    add(4, 0, 0, 1, G, R, 0, 0, 0);
    add(2, 0, 0, 1, Y, R, 0, 0, 0);
    add(4, 0, 0, 1, R, G, 0, 0, 0);
    add(2, 0, 0, 0, R, Y, 0, 0, 0);
    add(3, 0, 0, 0, G, R, 0, 0, 0);
    run_seq("walk2_side", 1'b1);

    // Request in WALK cycle 2 re-latches and is served on the next pass.
    add(1, 0, 1, 0, G, R, 0, 0, 0);
    add(3, 0, 0, 0, G, R, 0, 0, 0);
    add(2, 0, 0, 0, Y, R, 0, 0, 0);
    add(1, 0, 0, 0, R, R, 0, 1, 1);
    add(1, 1, 0, 0, R, R, 0, 1, 0);
    add(1, 0, 0, 0, R, R, 0, 1, 0);
    add(4, 0, 0, 0, G, R, 0, 0, 0);
    add(2, 0, 0, 0, Y, R, 0, 0, 0);
    add(1, 0, 0, 0, R, R, 1, 0, 1);
    add(2, 0, 0, 0, R, R, 1, 0, 0);
    add(3, 0, 0, 0, G, R, 0, 0, 0);
    run_seq("late_req", 1'b1);

    // Request in the first WALK cycle is lost to the clear.
    add(1, 0, 1, 0, G, R, 0, 0, 0);
    add(3, 0, 0, 0, G, R, 0, 0, 0);
    add(2, 0, 0, 0, Y, R, 0, 0, 0);
    add(1, 1, 0, 0, R, R, 0, 1, 1);
    add(2, 0, 0, 0, R, R, 0, 1, 0);
    add(8, 0, 0, 0, G, R, 0, 0, 0);
    run_seq("lost_req", 1'b1);

    // Reset pulsed mid-WALK at cycle 7.
    add(1, 1, 0, 0, G, R, 0, 0, 0);
    add(3, 0, 0, 0, G, R, 0, 0, 0);
    add(2, 0, 0, 0, Y, R, 0, 0, 0);
    add(1, 0, 0, 0, R, R, 1, 0, 1);
    run_seq("pre_rst", 1'b1);
    check("mid_walk_c7", R, R, 1'b1, 1'b0, 1'b0);
    #2 g_reset = 1'b1;
    #1 check("async_rst", G, R, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("rst_held", G, R, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    g_reset = 1'b0;
    add(4, 0, 0, 1, G, R, 0, 0, 0);
    add(2, 0, 0, 1, Y, R, 0, 0, 0);
    add(1, 0, 0, 0, R, G, 0, 0, 0);
    run_seq("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
